// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : ALU result-select encodings, skid states, width helpers    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_XOR  = 3'd2,
      ALU_SLT  = 3'd3,
      ALU_AND  = 3'd4,
      ALU_NAND = 3'd5,
      ALU_NOR  = 3'd6,
      ALU_OR   = 3'd7
   } alu_sel_e;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // A single-channel build still needs a 1-bit select.
   function automatic int sel_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// +----------------------------------------------------------------------+
// | pipe_skid_reg : 2-entry skid buffer, registered in_ready, 1-cycle    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_skid_reg
   import alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_payload,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_payload
);

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              w_push, w_pop;

   always_comb begin
      w_push     = in_valid && in_ready_q;
      w_pop      = (state_q != SKID_EMPTY) && out_ready;
      state_d    = state_q;
      head_d     = head_q;
      skid_d     = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (w_push) begin
               head_d  = in_payload;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (w_push && w_pop) begin
               head_d = in_payload;
            end else if (w_push) begin
               skid_d  = in_payload;
               state_d = SKID_FULL;
            end else if (w_pop) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (w_pop) begin
               head_d  = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      // Registered look-ahead keeps out_ready off the in_ready output path.
      in_ready_d = (state_d != SKID_FULL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SKID_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != SKID_EMPTY);
   assign out_payload = head_q;

endmodule

`default_nettype wire

// File: rtl/result_select_pipe.sv
// +----------------------------------------------------------------------+
// | result_select_pipe : channel select into a skid-buffered output      |
// | Optional zero flag port via macro RESULT_ZERO_FLAG_EN. Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module result_select_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 8,
   localparam int SEL_W = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err
`ifdef RESULT_ZERO_FLAG_EN
   ,
   output logic                    zero
`endif
);

`ifdef RESULT_ZERO_FLAG_EN
   localparam int ZERO_W = 1;
`else
   localparam int ZERO_W = 0;
`endif
   localparam int PAY_W = WIDTH + SEL_W + 1 + ZERO_W;

   logic [WIDTH-1:0] w_sel_data;
   logic             w_sel_hit;
   logic             w_sel_err;
   logic [PAY_W-1:0] w_pay_in;
   logic [PAY_W-1:0] w_pay_out;

   // Out-of-range selects match no channel and fall through to zero data.
   always_comb begin
      w_sel_data = '0;
      w_sel_hit  = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) begin
            w_sel_data = in_data[i*WIDTH +: WIDTH];
            w_sel_hit  = 1'b1;
         end
      end
      w_sel_err = !w_sel_hit;
   end

`ifdef RESULT_ZERO_FLAG_EN
   assign w_pay_in = {(w_sel_data == '0), w_sel_err, sel, w_sel_data};
   assign {zero, sel_err, out_sel, out_data} = w_pay_out;
`else
   assign w_pay_in = {w_sel_err, sel, w_sel_data};
   assign {sel_err, out_sel, out_data} = w_pay_out;
`endif

   pipe_skid_reg #(
      .DATA_W (PAY_W)
   ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (w_pay_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (w_pay_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_result_select_pipe.sv
// +----------------------------------------------------------------------+
// | tb_result_select_pipe : directed table + random model, NUM_IN 8 and 5 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_result_select_pipe;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [2:0]    sel = 3'd0;
   logic [W-1:0]  chan [8];
   logic [8*W-1:0] in_data8;
   logic [5*W-1:0] in_data5;

   always_comb begin
      in_data8 = '0;
      in_data5 = '0;
      for (int i = 0; i < 8; i++) in_data8[i*W +: W] = chan[i];
      for (int i = 0; i < 5; i++) in_data5[i*W +: W] = chan[i];
   end

   logic         rdy8, vld8, err8, rdy5, vld5, err5;
   logic [W-1:0] data8, data5;
   logic [2:0]   osel8, osel5;
`ifdef RESULT_ZERO_FLAG_EN
   logic         zero8, zero5;
`endif

   result_select_pipe #(.WIDTH(W), .NUM_IN(8)) dut8 (
`ifdef RESULT_ZERO_FLAG_EN
      .zero      (zero8),
`endif
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy8),
      .sel       (sel),
      .in_data   (in_data8),
      .out_valid (vld8),
      .out_ready (out_ready),
      .out_data  (data8),
      .out_sel   (osel8),
      .sel_err   (err8)
   );

   result_select_pipe #(.WIDTH(W), .NUM_IN(5)) dut5 (
`ifdef RESULT_ZERO_FLAG_EN
      .zero      (zero5),
`endif
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (rdy5),
      .sel       (sel),
      .in_data   (in_data5),
      .out_valid (vld5),
      .out_ready (out_ready),
      .out_data  (data5),
      .out_sel   (osel5),
      .sel_err   (err5)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_chan(input logic [31:0] base);
      for (int i = 0; i < 8; i++) chan[i] = base + 32'(i);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        vld;
      logic        rdy;
      logic [2:0]  s;
      logic [31:0] base;
      logic        e_vld;
      logic        e_rdy;
      logic [31:0] e_data;
      logic [2:0]  e_sel;
   } vec_t;

   function automatic vec_t mk(input logic vld, input logic rdy, input logic [2:0] s,
                               input logic [31:0] base, input logic e_vld, input logic e_rdy,
                               input logic [31:0] e_data, input logic [2:0] e_sel);
      vec_t v;
      v.vld = vld; v.rdy = rdy; v.s = s; v.base = base;
      v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_data = e_data; v.e_sel = e_sel;
      return v;
   endfunction

   typedef struct {
      logic [31:0] data;
      logic [2:0]  sel;
      logic        err;
   } beat_t;

   // Expected beat from the selection rule applied to the current inputs.
   function automatic beat_t ref_beat(input int n);
      beat_t b;
      b.sel = sel;
      if (int'(sel) < n) begin
         b.data = chan[sel];
         b.err  = 1'b0;
      end else begin
         b.data = 32'd0;
         b.err  = 1'b1;
      end
      return b;
   endfunction

   vec_t  tbl[$];
   beat_t q8[$];
   beat_t q5[$];
   logic  exp_rdy;
   logic  do_rst, do_push, do_pop;

   initial begin
      // Streaming: one beat per cycle, each visible after its edge.
      for (int s = 0; s < 8; s++)
         tbl.push_back(mk(1, 1, 3'(s), 32'h1000_0000, 1, 1, 32'h1000_0000 + 32'(s), 3'(s)));
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 1, 32'h0, 0));
      // Backpressure: two accepted, third refused, then ordered drain.
      tbl.push_back(mk(1, 0, 1, 32'h2000_0000, 1, 1, 32'h2000_0001, 1));
      tbl.push_back(mk(1, 0, 2, 32'h2000_0000, 1, 0, 32'h2000_0001, 1));
      tbl.push_back(mk(1, 0, 3, 32'h2000_0000, 1, 0, 32'h2000_0001, 1));
      tbl.push_back(mk(0, 1, 3, 32'h2000_0000, 1, 1, 32'h2000_0002, 2));
      tbl.push_back(mk(0, 1, 3, 32'h2000_0000, 0, 1, 32'h0, 0));
      // Simultaneous push and pop while holding one beat.
      tbl.push_back(mk(1, 0, 0, 32'hAAAA_AAAA, 1, 1, 32'hAAAA_AAAA, 0));
      tbl.push_back(mk(1, 1, 0, 32'h5555_5555, 1, 1, 32'h5555_5555, 0));
      tbl.push_back(mk(1, 1, 0, 32'hAAAA_AAAA, 1, 1, 32'hAAAA_AAAA, 0));
      tbl.push_back(mk(1, 1, 0, 32'h5555_5555, 1, 1, 32'h5555_5555, 0));
      tbl.push_back(mk(0, 1, 0, 32'h0, 0, 1, 32'h0, 0));

      set_chan(32'h0);
      reset = 1'b1;
      repeat (3) tick();
      check("rst_valid", vld8, 0);
      check("rst_ready", rdy8, 0);
      check("rst_data", data8, 0);
      check("rst_sel", osel8, 0);
      check("rst_err", err8, 0);
`ifdef RESULT_ZERO_FLAG_EN
      check("rst_zero", zero8, 0);
`endif
      reset = 1'b0;
      #1;
      check("ready_before_edge", rdy8, 0);
      tick();
      check("ready_after_release", rdy8, 1);

      foreach (tbl[k]) begin
         in_valid  = tbl[k].vld;
         out_ready = tbl[k].rdy;
         sel       = tbl[k].s;
         set_chan(tbl[k].base);
         tick();
         check($sformatf("tbl%0d_valid", k), vld8, tbl[k].e_vld);
         check($sformatf("tbl%0d_ready", k), rdy8, tbl[k].e_rdy);
         if (tbl[k].e_vld) begin
            check($sformatf("tbl%0d_data", k), data8, tbl[k].e_data);
            check($sformatf("tbl%0d_sel", k), osel8, tbl[k].e_sel);
            check($sformatf("tbl%0d_err", k), err8, 0);
         end
      end

      // Out-of-range select on the 5-channel instance.
      in_valid = 1; out_ready = 1; sel = 3'd6; set_chan(32'h3000_0000);
      tick();
      check("oor_data5", data5, 0);
      check("oor_err5", err5, 1);
      check("oor_sel5", osel5, 6);
      check("oor_data8", data8, 32'h3000_0006);
      check("oor_err8", err8, 0);
      sel = 3'd4;
      tick();
      check("inr_data5", data5, 32'h3000_0004);
      check("inr_err5", err5, 0);
      check("inr_sel5", osel5, 4);
      in_valid = 0;
      tick();
      check("oor_drained", vld5, 0);

      // All-zero channel versus non-zero.
      in_valid = 1; sel = 3'd0; set_chan(32'h0);
      tick();
      check("zero_data", data8, 0);
`ifdef RESULT_ZERO_FLAG_EN
      check("zero_flag_set", zero8, 1);
`endif
      set_chan(32'h1);
      tick();
      check("nonzero_data", data8, 1);
`ifdef RESULT_ZERO_FLAG_EN
      check("zero_flag_clear", zero8, 0);
`endif
      in_valid = 0;
      tick();

      // Reset while full.
      in_valid = 1; out_ready = 0; sel = 3'd5; set_chan(32'h4000_0000);
      tick();
      sel = 3'd2;
      tick();
      check("full_ready", rdy8, 0);
      check("full_valid", vld8, 1);
      check("full_head", data8, 32'h4000_0005);
      reset = 1'b1;
      #1;
      check("rst_mid_valid", vld8, 0);
      check("rst_mid_ready", rdy8, 0);
      in_valid = 0; out_ready = 1;
      tick();
      reset = 1'b0;
      tick();
      check("rst_mid_ready_back", rdy8, 1);
      check("rst_mid_empty", vld8, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_stale_beat", vld8, 0);
      end

      // Random traffic against a queue model, both instances in lockstep.
      exp_rdy = 1'b1;
      for (int c = 0; c < 600; c++) begin
         do_rst    = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         sel       = 3'($urandom_range(0, 7));
         for (int i = 0; i < 8; i++)
            chan[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
         reset = do_rst;
         @(posedge clk);
         if (do_rst) begin
            q8.delete();
            q5.delete();
            exp_rdy = 1'b0;
         end else begin
            do_pop  = (q8.size() > 0) && out_ready;
            do_push = in_valid && exp_rdy;
            if (do_pop) begin
               void'(q8.pop_front());
               void'(q5.pop_front());
            end
            if (do_push) begin
               q8.push_back(ref_beat(8));
               q5.push_back(ref_beat(5));
            end
            exp_rdy = (q8.size() < 2);
         end
         #1;
         check("rnd_valid8", vld8, q8.size() > 0);
         check("rnd_ready8", rdy8, exp_rdy);
         check("rnd_valid5", vld5, q5.size() > 0);
         check("rnd_ready5", rdy5, exp_rdy);
         if (q8.size() > 0) begin
            check("rnd_data8", data8, q8[0].data);
            check("rnd_sel8", osel8, q8[0].sel);
            check("rnd_err8", err8, q8[0].err);
`ifdef RESULT_ZERO_FLAG_EN
            check("rnd_zero8", zero8, q8[0].data == 32'h0);
`endif
         end
         if (q5.size() > 0) begin
            check("rnd_data5", data5, q5[0].data);
            check("rnd_sel5", osel5, q5[0].sel);
            check("rnd_err5", err5, q5[0].err);
`ifdef RESULT_ZERO_FLAG_EN
            check("rnd_zero5", zero5, q5[0].data == 32'h0);
`endif
         end
      end
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
